// File: rtl/sv_uart_pkg.sv
// Shared types and constants for the sv_uart transmit-side blocks.
package sv_uart_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_GAP} arb_state_t;

  localparam int GAP_W = 16;

endpackage

// File: rtl/sv_uart_rr_pick.sv
// Combinational round-robin picker: first set ivalid bit at or after iptr, with wrap.
module sv_uart_rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] ivalid,
  input  logic [ID_W-1:0]  iptr,
  output logic [N_REQ-1:0] ogrant,
  output logic [ID_W-1:0]  oidx,
  output logic             oany
);

  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;
  logic               found;

  // Rotating the doubled vector puts iptr at bit 0, so a plain lowest-bit
  // priority encode yields the distance from iptr to the winner.
  always_comb begin
    dbl   = {ivalid, ivalid} >> iptr;
    rot   = dbl[N_REQ-1:0];
    oany  = |ivalid;
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        off   = ID_W'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, iptr} + {1'b0, off};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    oidx   = sum[ID_W-1:0];
    ogrant = '0;
    if (oany) ogrant[oidx] = 1'b1;
  end

endmodule

// File: rtl/sv_uart_tx_arbiter.sv
// Round-robin arbiter sharing the sv_uart_engine transmit path between N_REQ
// AXI-stream producers, with a programmable idle gap after each engine handshake.
module sv_uart_tx_arbiter
  import sv_uart_pkg::*;
#(
  parameter  int DATA_WIDTH = 24,
  parameter  int N_REQ      = 4,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                        iclk,
  input  logic                        irst,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_REQ-1:0]            s_axis_tvalid,
  output logic [N_REQ-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [ID_W-1:0]             m_axis_tid,
  input  logic [GAP_W-1:0]            igap,
  output logic                        obusy
);

  arb_state_t            state_q, state_d;
  logic [ID_W-1:0]       rr_ptr;
  logic [GAP_W-1:0]      gap_cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ID_W-1:0]       tid_q;

  logic [N_REQ-1:0]      pick_grant;
  logic [ID_W-1:0]       pick_idx;
  logic                  pick_any;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  accept;
  logic                  handshake;

  sv_uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .ivalid (s_axis_tvalid),
    .iptr   (rr_ptr),
    .ogrant (pick_grant),
    .oidx   (pick_idx),
    .oany   (pick_any)
  );

  always_comb begin
    win_data  = s_axis_tdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
    accept    = (state_q == ARB_IDLE) && pick_any;
    handshake = (state_q == ARB_SEND) && m_axis_tready;
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (pick_any)       state_d = ARB_SEND;
      ARB_SEND: if (m_axis_tready)  state_d = ARB_GAP;
      ARB_GAP:  if (gap_cnt == '0)  state_d = ARB_IDLE;
      default:                      state_d = ARB_IDLE;
    endcase
  end

  // Grant is gated by irst so no requester sees a handshake while reset is held.
  always_comb begin
    obusy         = (state_q != ARB_IDLE);
    m_axis_tvalid = (state_q == ARB_SEND);
    s_axis_tready = ((state_q == ARB_IDLE) && !irst) ? pick_grant : '0;
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      rr_ptr  <= '0;
      gap_cnt <= '0;
      data_q  <= '0;
      tid_q   <= '0;
    end else begin
      if (accept) begin
        data_q <= win_data;
        tid_q  <= pick_idx;
      end
      if (handshake) begin
        rr_ptr  <= (tid_q == ID_W'(N_REQ-1)) ? '0 : tid_q + 1'b1;
        gap_cnt <= igap;
      end else if ((state_q == ARB_GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  assign m_axis_tdata = data_q;
  assign m_axis_tid   = tid_q;

endmodule

// File: tb/tb_sv_uart_tx_arbiter.sv
// Self-checking bench for sv_uart_tx_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural round-robin model.
module tb_sv_uart_tx_arbiter;

  localparam int DW  = 24;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic          iclk = 1'b0;
  logic          irst;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]  s_axis_tvalid;
  logic [N-1:0]  s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [IDW-1:0] m_axis_tid;
  logic [15:0]   igap;
  logic          obusy;

  always #5 iclk = ~iclk;

  sv_uart_tx_arbiter #(.DATA_WIDTH(DW), .N_REQ(N)) dut (
    .iclk          (iclk),
    .irst          (irst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tid    (m_axis_tid),
    .igap          (igap),
    .obusy         (obusy)
  );

  int    n_assert = 0;
  int    n_fail   = 0;
  string phase    = "init";

  logic [DW-1:0] rdata [N];

  // Model: a word is either held for the engine, or a gap countdown runs, or we are idle.
  bit            m_hold;
  logic [DW-1:0] m_data;
  int            m_id;
  int            m_ptr;
  int            m_gap;

  int            dut_ids[$];
  logic [DW-1:0] dut_data[$];
  int            gap_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Called at posedge+1; applies inputs, checks at negedge, advances model, returns at next posedge+1.
  task automatic cycle(input logic [N-1:0] v, input logic tr);
    int         win;
    bit         idle;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) s_axis_tdata[i*DW +: DW] = rdata[i];
    s_axis_tvalid = v;
    m_axis_tready = tr;
    @(negedge iclk);
    idle    = !m_hold && (m_gap == 0);
    win     = idle ? pick(v, m_ptr) : -1;
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("s_tready", 32'(s_axis_tready), 32'(exp_rdy));
    chk("m_tvalid", 32'(m_axis_tvalid), 32'(m_hold));
    chk("obusy",    32'(obusy),         32'(!idle));
    if (m_hold) begin
      chk("m_tdata", 32'(m_axis_tdata), 32'(m_data));
      chk("m_tid",   32'(m_axis_tid),   32'(m_id));
    end
    if (m_axis_tvalid && m_axis_tready) begin
      dut_ids.push_back(int'(m_axis_tid));
      dut_data.push_back(m_axis_tdata);
    end
    if (obusy && !m_axis_tvalid) gap_seen++;
    if (idle && win >= 0) begin
      m_hold = 1'b1;
      m_data = rdata[win];
      m_id   = win;
    end else if (m_hold && tr) begin
      m_hold = 1'b0;
      m_gap  = int'(igap) + 1;
      m_ptr  = (m_id + 1) % N;
    end else if (m_gap > 0) begin
      m_gap--;
    end
    @(posedge iclk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++)
      if (m_hold || m_gap != 0) cycle('0, 1'b1);
  endtask

  // Asserts reset between clock edges so the outputs must fall without a clock.
  task automatic do_reset();
    s_axis_tvalid = '1;
    irst = 1'b1;
    #2;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_obusy",  32'(obusy),         32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst_tid",    32'(m_axis_tid),    32'd0);
    @(posedge iclk);
    #1;
    chk("rst_tready_held", 32'(s_axis_tready), 32'd0);
    irst   = 1'b0;
    m_hold = 1'b0;
    m_gap  = 0;
    m_ptr  = 0;
  endtask

  initial begin
    irst          = 1'b0;
    igap          = '0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < N; i++) rdata[i] = '0;
    #1;

    phase = "reset";
    do_reset();

    phase = "single";
    rdata[1] = 24'hA1B2C3;
    dut_ids.delete();
    dut_data.delete();
    cycle(4'b0010, 1'b1);
    repeat (4) cycle('0, 1'b1);
    chk("count", 32'(dut_ids.size()), 32'd1);
    if (dut_ids.size() > 0) begin
      chk("tid",  32'(dut_ids[0]),  32'd1);
      chk("data", 32'(dut_data[0]), 32'hA1B2C3);
    end
    cycle('1, 1'b1);
    drain();

    phase = "rr_all";
    do_reset();
    rdata[0] = 24'h11; rdata[1] = 24'h22; rdata[2] = 24'h33; rdata[3] = 24'h44;
    dut_ids.delete();
    dut_data.delete();
    repeat (24) cycle('1, 1'b1);
    drain();
    chk("count", 32'(dut_ids.size()), 32'd8);
    for (int k = 0; k < 8 && k < dut_ids.size(); k++) begin
      chk("order_tid",  32'(dut_ids[k]),  32'(k % N));
      chk("order_data", 32'(dut_data[k]), 32'((k % N + 1) * 'h11));
    end

    phase = "stall";
    dut_ids.delete();
    dut_data.delete();
    cycle('1, 1'b0);
    repeat (50) cycle('1, 1'b0);
    repeat (5) cycle('0, 1'b1);
    chk("transfers", 32'(dut_ids.size()), 32'd1);
    drain();

    phase = "gap";
    igap = 16'd5;
    cycle(4'b0100, 1'b1);
    cycle(4'b0100, 1'b1);
    gap_seen = 0;
    igap = 16'd9;
    repeat (7) cycle(4'b0100, 1'b1);
    chk("gap_cycles", 32'(gap_seen), 32'd6);
    drain();
    igap = '0;

    phase = "rst_send";
    rdata[0] = 24'h0000A5;
    cycle('1, 1'b0);
    cycle('1, 1'b0);
    do_reset();
    dut_ids.delete();
    dut_data.delete();
    cycle('1, 1'b1);
    cycle('1, 1'b1);
    chk("count", 32'(dut_ids.size()), 32'd1);
    if (dut_ids.size() > 0) begin
      chk("next_req0_tid",  32'(dut_ids[0]),  32'd0);
      chk("next_req0_data", 32'(dut_data[0]), 32'h0000A5);
    end
    drain();

    phase = "random";
    repeat (400) begin
      for (int i = 0; i < N; i++) rdata[i] = DW'($urandom);
      igap = 16'($urandom_range(0, 3));
      cycle(N'($urandom), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
